// File: rtl/shadowmask_pkg.sv
// Shared opcodes, state encoding and ROM layout constants for the shadow-mask loader.
package shadowmask_pkg;

   localparam logic [2:0] OP_CTRL = 3'b000;
   localparam logic [2:0] OP_VMAX = 3'b001;
   localparam logic [2:0] OP_HMAX = 3'b010;
   localparam logic [2:0] OP_LUT  = 3'b011;

   localparam int         LUT_ENTRIES = 64;
   localparam logic [6:0] HDR_IDX     = 7'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTRL,
      ST_DIS,
      ST_VMAX,
      ST_HMAX,
      ST_LUT,
      ST_FIN
   } state_t;

   // The mask block only accepts sizes up to 7; larger header nibbles saturate.
   function automatic logic [3:0] clamp7(input logic [3:0] v);
      return (v > 4'd7) ? 4'd7 : v;
   endfunction

endpackage

// File: rtl/shadowmask_loader_if.sv
// Pattern ROM read port plus the command bus towards the shadow-mask block.
interface shadowmask_loader_if #(
   parameter int SEL_W  = 3,
   parameter int ROM_AW = SEL_W + 7
);

   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              cmd_wr;
   logic [15:0]       cmd_in;
   logic              busy;
   logic              done;

   modport master (
      output rom_addr,
      output cmd_wr,
      output cmd_in,
      output busy,
      output done,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      input  cmd_wr,
      input  cmd_in,
      input  busy,
      input  done,
      output rom_data
   );

endinterface

// File: rtl/shadowmask_loader.sv
// Replays a pattern from the mask ROM as a 68-command burst and forwards control-bit
// changes to the shadow-mask block as single CTRL writes.
module shadowmask_loader
   import shadowmask_pkg::*;
#(
   parameter int SEL_W  = 3,
   parameter int ROM_AW = SEL_W + 7
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [SEL_W-1:0] mask_sel,
   input  logic             mask_2x,
   input  logic             mask_rotate,
   input  logic             mask_en,
   input  logic             force_reload,
   shadowmask_loader_if.master bus
);

   state_t            state;
   state_t            state_nxt;
   logic              reload_pend;
   logic [SEL_W-1:0]  applied_sel;
   logic [SEL_W-1:0]  sel_l;
   logic [2:0]        applied_ctrl;
   logic [2:0]        ctrl_live;
   logic [6:0]        idx;
   logic [5:0]        lut_k;
   logic              load_req;
   logic              sel_off;
   logic [ROM_AW-1:0] rom_addr_w;

   assign sel_off    = (mask_sel == '0);
   assign ctrl_live  = {mask_rotate, mask_2x, mask_en & ~sel_off};
   assign load_req   = reload_pend | (mask_sel != applied_sel);
   // ROM data lags the address by one cycle, so LUT entry k is on the bus while idx = k+2.
   assign lut_k      = idx[5:0] - 6'd2;
   assign rom_addr_w = {sel_l, idx};
   assign bus.rom_addr = rom_addr_w;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (load_req) begin
               state_nxt = sel_off ? ST_CTRL : ST_DIS;
            end else if (ctrl_live != applied_ctrl) begin
               state_nxt = ST_CTRL;
            end
         end
         ST_CTRL: state_nxt = ST_IDLE;
         ST_DIS:  state_nxt = ST_VMAX;
         ST_VMAX: state_nxt = ST_HMAX;
         ST_HMAX: state_nxt = ST_LUT;
         ST_LUT: begin
            if (lut_k == 6'(LUT_ENTRIES - 1)) begin
               state_nxt = ST_FIN;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_wr = 1'b0;
      bus.cmd_in = 16'h0000;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state)
         ST_CTRL: begin
            bus.cmd_wr = 1'b1;
            bus.cmd_in = {OP_CTRL, 10'd0, applied_ctrl};
         end
         ST_DIS: begin
            bus.cmd_wr = 1'b1;
            bus.busy   = 1'b1;
            bus.cmd_in = {OP_CTRL, 10'd0, applied_ctrl};
         end
         ST_VMAX: begin
            bus.cmd_wr = 1'b1;
            bus.busy   = 1'b1;
            bus.cmd_in = {OP_VMAX, 9'd0, clamp7(bus.rom_data[7:4])};
         end
         ST_HMAX: begin
            bus.cmd_wr = 1'b1;
            bus.busy   = 1'b1;
            bus.cmd_in = {OP_HMAX, 9'd0, clamp7(bus.rom_data[3:0])};
         end
         ST_LUT: begin
            bus.cmd_wr = 1'b1;
            bus.busy   = 1'b1;
            bus.cmd_in = {OP_LUT, 3'd0, lut_k, 1'b0, bus.rom_data[2:0]};
         end
         ST_FIN: begin
            bus.cmd_wr = 1'b1;
            bus.busy   = 1'b1;
            bus.done   = 1'b1;
            bus.cmd_in = {OP_CTRL, 10'd0, ctrl_live};
         end
         default: begin
            bus.cmd_wr = 1'b0;
         end
      endcase
   end

   // Shadow registers follow what has actually been written to the mask block, so the
   // idle compare against the live inputs decides what still needs to be sent.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         reload_pend  <= 1'b1;
         applied_sel  <= '0;
         applied_ctrl <= 3'b000;
         sel_l        <= '0;
         idx          <= HDR_IDX;
      end else begin
         if (force_reload) begin
            reload_pend <= 1'b1;
         end else if (state == ST_IDLE && load_req) begin
            reload_pend <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (load_req && sel_off) begin
                  applied_sel  <= '0;
                  applied_ctrl <= ctrl_live;
               end else if (load_req) begin
                  sel_l           <= mask_sel;
                  idx             <= HDR_IDX;
                  applied_ctrl[0] <= 1'b0;
               end else if (ctrl_live != applied_ctrl) begin
                  applied_ctrl <= ctrl_live;
               end
            end
            ST_VMAX, ST_HMAX, ST_LUT: begin
               idx <= idx + 7'd1;
            end
            ST_FIN: begin
               applied_sel  <= sel_l;
               applied_ctrl <= ctrl_live;
            end
            default: begin
               idx <= idx;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shadowmask_loader.sv
// Directed bench for shadowmask_loader with a behavioural pattern ROM (header + LUT bytes k%8).
module tb_shadowmask_loader;

   logic       clk_sys      = 1'b0;
   logic       reset_n      = 1'b0;
   logic [2:0] mask_sel     = 3'd2;
   logic       mask_2x      = 1'b0;
   logic       mask_rotate  = 1'b0;
   logic       mask_en      = 1'b1;
   logic       force_reload = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int done_cnt = 0;
   int busy_seen = 0;
   int addr_changes = 0;
   int r_cyc;
   int t_done;
   int n_poll;
   logic [9:0] last_addr = '0;

   logic [15:0] wr_q [$];
   logic [9:0]  addr_q [$];
   logic        done_q [$];
   int          cyc_q [$];
   logic [7:0]  hdr_tab [0:7];

   shadowmask_loader_if #(.SEL_W(3)) bus();

   shadowmask_loader #(.SEL_W(3)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .mask_sel     (mask_sel),
      .mask_2x      (mask_2x),
      .mask_rotate  (mask_rotate),
      .mask_en      (mask_en),
      .force_reload (force_reload),
      .bus          (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   function automatic logic [7:0] rom_byte(input logic [9:0] a);
      if (a[6:0] == 7'd0) return hdr_tab[a[9:7]];
      return {5'b10101, 3'(a[6:0] - 7'd1)};
   endfunction

   always @(posedge clk_sys) bus.rom_data <= rom_byte(bus.rom_addr);

   always @(negedge clk_sys) begin
      if (bus.cmd_wr === 1'b1) begin
         wr_q.push_back(bus.cmd_in);
         addr_q.push_back(bus.rom_addr);
         done_q.push_back(bus.done);
         cyc_q.push_back(cyc);
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) busy_seen = 1;
      if (bus.rom_addr !== last_addr) addr_changes++;
      last_addr = bus.rom_addr;
   end

   // Expected command j (0..67) of a full load.
   function automatic logic [15:0] exp_word(input int j, input logic [7:0] hdr, input logic [2:0] fin);
      logic [3:0] v;
      logic [3:0] h;
      v = (hdr[7:4] > 4'd7) ? 4'd7 : hdr[7:4];
      h = (hdr[3:0] > 4'd7) ? 4'd7 : hdr[3:0];
      if (j == 0)  return 16'h0000;
      if (j == 1)  return 16'h2000 | {12'd0, v};
      if (j == 2)  return 16'h4000 | {12'd0, h};
      if (j == 67) return {13'd0, fin};
      return 16'h6000 | 16'((j - 3) << 4) | 16'((j - 3) % 8);
   endfunction

   function automatic logic [9:0] exp_addr(input int sel, input int j);
      return 10'(sel * 128 + ((j < 2) ? 0 : j - 1));
   endfunction

   task automatic clear_capture();
      wr_q.delete();
      addr_q.delete();
      done_q.delete();
      cyc_q.delete();
      busy_seen = 0;
      addr_changes = 0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < 400) begin
         @(posedge clk_sys); #1;
         n++;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("[TB] FAIL %s timeout: done pulses %0d, required %0d", name, done_cnt, target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      checks++; if (bus.cmd_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_wr got %b exp 0", bus.cmd_wr); end
      checks++; if (bus.cmd_in !== 16'h0) begin errors++; $display("[TB] FAIL reset_cmd_in got %h exp 0000", bus.cmd_in); end
      checks++; if (bus.rom_addr !== 10'h0) begin errors++; $display("[TB] FAIL reset_rom_addr got %h exp 000", bus.rom_addr); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", bus.done); end
   endtask

   task automatic test_full_load();
      clear_capture();
      t_done = done_cnt + 1;
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      r_cyc = cyc;
      wait_done(t_done, "full_load");
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL load_busy_after got %b exp 0", bus.busy); end
      checks++; if (wr_q.size() != 68) begin errors++; $display("[TB] FAIL load_count got %0d exp 68", wr_q.size()); end
      for (int j = 0; j < 68; j++) begin
         if (j < wr_q.size()) begin
            checks++;
            if (wr_q[j] !== exp_word(j, 8'h53, 3'b001)) begin
               errors++; $display("[TB] FAIL load_word[%0d] got %h exp %h", j, wr_q[j], exp_word(j, 8'h53, 3'b001));
            end
            checks++;
            if (done_q[j] !== (j == 67 ? 1'b1 : 1'b0)) begin
               errors++; $display("[TB] FAIL load_done[%0d] got %b exp %b", j, done_q[j], (j == 67));
            end
            if (j <= 65) begin
               checks++;
               if (addr_q[j] !== exp_addr(2, j)) begin
                  errors++; $display("[TB] FAIL load_addr[%0d] got %h exp %h", j, addr_q[j], exp_addr(2, j));
               end
            end
         end
      end
      if (wr_q.size() == 68) begin
         checks++; if (cyc_q[0] != r_cyc + 1) begin errors++; $display("[TB] FAIL load_first_cycle got %0d exp %0d", cyc_q[0], r_cyc + 1); end
         checks++; if (cyc_q[67] != r_cyc + 68) begin errors++; $display("[TB] FAIL load_last_cycle got %0d exp %0d", cyc_q[67], r_cyc + 68); end
      end
   endtask

   task automatic test_ctrl_toggle();
      clear_capture();
      @(posedge clk_sys); #1;
      mask_rotate = 1'b1;
      r_cyc = cyc;
      repeat (4) @(posedge clk_sys);
      #1;
      checks++; if (wr_q.size() != 1) begin errors++; $display("[TB] FAIL rot_count got %0d exp 1", wr_q.size()); end
      if (wr_q.size() > 0) begin
         checks++; if (wr_q[0] !== 16'h0005) begin errors++; $display("[TB] FAIL rot_word got %h exp 0005", wr_q[0]); end
         checks++; if (cyc_q[0] != r_cyc + 1) begin errors++; $display("[TB] FAIL rot_cycle got %0d exp %0d", cyc_q[0], r_cyc + 1); end
      end
      checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL rot_busy got %0d exp 0", busy_seen); end
      clear_capture();
      mask_rotate = 1'b0;
      repeat (4) @(posedge clk_sys);
      #1;
      checks++; if (wr_q.size() != 1) begin errors++; $display("[TB] FAIL unrot_count got %0d exp 1", wr_q.size()); end
      if (wr_q.size() > 0) begin
         checks++; if (wr_q[0] !== 16'h0001) begin errors++; $display("[TB] FAIL unrot_word got %h exp 0001", wr_q[0]); end
      end
   endtask

   task automatic test_sel_off();
      clear_capture();
      @(posedge clk_sys); #1;
      mask_sel = 3'd0;
      repeat (4) @(posedge clk_sys);
      #1;
      checks++; if (wr_q.size() != 1) begin errors++; $display("[TB] FAIL off_count got %0d exp 1", wr_q.size()); end
      if (wr_q.size() > 0) begin
         checks++; if (wr_q[0] !== 16'h0000) begin errors++; $display("[TB] FAIL off_word got %h exp 0000", wr_q[0]); end
      end
      checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL off_busy got %0d exp 0", busy_seen); end
      checks++; if (addr_changes != 0) begin errors++; $display("[TB] FAIL off_rom_reads got %0d addr changes exp 0", addr_changes); end
      clear_capture();
      t_done = done_cnt + 1;
      mask_sel = 3'd2;
      wait_done(t_done, "sel_on");
      checks++; if (wr_q.size() != 68) begin errors++; $display("[TB] FAIL on_count got %0d exp 68", wr_q.size()); end
      if (wr_q.size() == 68) begin
         checks++; if (wr_q[0] !== 16'h0000) begin errors++; $display("[TB] FAIL on_dis got %h exp 0000", wr_q[0]); end
         checks++; if (wr_q[67] !== 16'h0001) begin errors++; $display("[TB] FAIL on_fin got %h exp 0001", wr_q[67]); end
         checks++; if (addr_q[0] !== 10'd256) begin errors++; $display("[TB] FAIL on_addr got %h exp 100", addr_q[0]); end
      end
   endtask

   task automatic test_sel_change_midload();
      clear_capture();
      t_done = done_cnt + 2;
      @(posedge clk_sys); #1;
      force_reload = 1'b1;
      r_cyc = cyc;
      @(posedge clk_sys); #1;
      force_reload = 1'b0;
      n_poll = 0;
      while (wr_q.size() < 19 && n_poll < 200) begin
         @(posedge clk_sys); #1;
         n_poll++;
      end
      mask_sel = 3'd3;
      wait_done(t_done, "midload");
      checks++; if (wr_q.size() != 136) begin errors++; $display("[TB] FAIL mid_count got %0d exp 136", wr_q.size()); end
      if (wr_q.size() == 136) begin
         for (int j = 0; j < 68; j++) begin
            checks++;
            if (wr_q[j] !== exp_word(j, 8'h53, 3'b001)) begin
               errors++; $display("[TB] FAIL mid_a_word[%0d] got %h exp %h", j, wr_q[j], exp_word(j, 8'h53, 3'b001));
            end
            checks++;
            if (wr_q[68 + j] !== exp_word(j, 8'h26, 3'b001)) begin
               errors++; $display("[TB] FAIL mid_b_word[%0d] got %h exp %h", j, wr_q[68 + j], exp_word(j, 8'h26, 3'b001));
            end
            if (j <= 65) begin
               checks++;
               if (addr_q[j] !== exp_addr(2, j)) begin
                  errors++; $display("[TB] FAIL mid_a_addr[%0d] got %h exp %h", j, addr_q[j], exp_addr(2, j));
               end
               checks++;
               if (addr_q[68 + j] !== exp_addr(3, j)) begin
                  errors++; $display("[TB] FAIL mid_b_addr[%0d] got %h exp %h", j, addr_q[68 + j], exp_addr(3, j));
               end
            end
         end
         checks++; if (cyc_q[0] != r_cyc + 2) begin errors++; $display("[TB] FAIL mid_a_start got %0d exp %0d", cyc_q[0], r_cyc + 2); end
         checks++; if (cyc_q[68] != r_cyc + 71) begin errors++; $display("[TB] FAIL mid_b_start got %0d exp %0d", cyc_q[68], r_cyc + 71); end
         checks++; if (cyc_q[135] != r_cyc + 138) begin errors++; $display("[TB] FAIL mid_b_end got %0d exp %0d", cyc_q[135], r_cyc + 138); end
      end
   endtask

   task automatic test_force_reload_reset();
      hdr_tab[2] = 8'hFF;
      clear_capture();
      t_done = done_cnt + 1;
      @(posedge clk_sys); #1;
      mask_sel = 3'd2;
      @(posedge clk_sys); #1;
      force_reload = 1'b1;
      @(posedge clk_sys); #1;
      force_reload = 1'b0;
      wait_done(t_done, "reload_first");
      n_poll = 0;
      while (wr_q.size() < 97 && n_poll < 200) begin
         @(posedge clk_sys); #1;
         n_poll++;
      end
      checks++; if (bus.cmd_wr !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_cmd_wr got %b exp 1", bus.cmd_wr); end
      reset_n = 1'b0;
      #1;
      checks++; if (bus.cmd_wr !== 1'b0) begin errors++; $display("[TB] FAIL midreset_cmd_wr got %b exp 0", bus.cmd_wr); end
      checks++; if (bus.cmd_in !== 16'h0) begin errors++; $display("[TB] FAIL midreset_cmd_in got %h exp 0000", bus.cmd_in); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.rom_addr !== 10'h0) begin errors++; $display("[TB] FAIL midreset_rom_addr got %h exp 000", bus.rom_addr); end
      checks++; if (wr_q.size() != 97) begin errors++; $display("[TB] FAIL reload_count got %0d exp 97", wr_q.size()); end
      if (wr_q.size() == 97) begin
         for (int j = 0; j < 68; j++) begin
            checks++;
            if (wr_q[j] !== exp_word(j, 8'hFF, 3'b001)) begin
               errors++; $display("[TB] FAIL reload_a_word[%0d] got %h exp %h", j, wr_q[j], exp_word(j, 8'hFF, 3'b001));
            end
            if (j < 29) begin
               checks++;
               if (wr_q[68 + j] !== exp_word(j, 8'hFF, 3'b001)) begin
                  errors++; $display("[TB] FAIL reload_b_word[%0d] got %h exp %h", j, wr_q[68 + j], exp_word(j, 8'hFF, 3'b001));
               end
            end
         end
      end
      repeat (2) @(posedge clk_sys);
      #1;
      clear_capture();
      t_done = done_cnt + 1;
      reset_n = 1'b1;
      r_cyc = cyc;
      wait_done(t_done, "after_reset");
      checks++; if (wr_q.size() != 68) begin errors++; $display("[TB] FAIL rst_load_count got %0d exp 68", wr_q.size()); end
      if (wr_q.size() == 68) begin
         checks++; if (cyc_q[0] != r_cyc + 1) begin errors++; $display("[TB] FAIL rst_load_start got %0d exp %0d", cyc_q[0], r_cyc + 1); end
         checks++; if (wr_q[1] !== 16'h2007) begin errors++; $display("[TB] FAIL rst_load_vmax got %h exp 2007", wr_q[1]); end
         checks++; if (wr_q[2] !== 16'h4007) begin errors++; $display("[TB] FAIL rst_load_hmax got %h exp 4007", wr_q[2]); end
         checks++; if (wr_q[67] !== 16'h0001) begin errors++; $display("[TB] FAIL rst_load_fin got %h exp 0001", wr_q[67]); end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) hdr_tab[i] = 8'h53;
      hdr_tab[3] = 8'h26;
      test_reset();
      test_full_load();
      test_ctrl_toggle();
      test_sel_off();
      test_sel_change_midload();
      test_force_reload_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
